// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the unified memory-port arbiter.
//             Provides the arbiter state encoding, the access-size encodings
//             and the size used for instruction fetches.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DATA_WAIT  = 2'd1,
      ST_FETCH_WAIT = 2'd2,
      ST_FETCH_DROP = 2'd3
   } arb_state_e;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] FETCH_SIZE = SZ_WORD;

   // The reserved encoding 11 is presented to memory as a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Arbitrates one unified instruction/data memory port between the
//             IF-stage fetch requester and the MEM-stage load/store requester.
//             Data has priority; a saturating burst counter forces a fetch
//             grant after MAX_DATA_BURST consecutive data grants while a fetch
//             waits. A flush cancels an in-flight fetch but still retires the
//             memory access so the port is never left mid-transaction.
//  Ports    :
//    clk, rst                   clock, asynchronous active-low reset
//    if_req/if_addr/if_flush    fetch request, address, cancel
//    if_ready/if_rdata          fetch completion pulse and word
//    dm_req/dm_we/dm_size/
//    dm_addr/dm_wdata           data request and attributes
//    dm_ready/dm_rdata          data completion pulse and raw load word
//    mem_req/mem_we/mem_size/
//    mem_addr/mem_wdata         registered memory access strobe/attributes
//    mem_ack/mem_rdata          memory completion and read data
//    busy                       arbiter not idle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_size,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int                 BURST_W   = $clog2(MAX_DATA_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

   arb_state_e          state_q,     state_d;
   logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic                mem_req_q,   mem_req_d;
   logic                mem_we_q,    mem_we_d;
   logic [1:0]          mem_size_q,  mem_size_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_ready_q,  if_ready_d;
   logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
   logic                dm_ready_q,  dm_ready_d;
   logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

   logic fetch_elig;
   logic burst_at_max;
   logic retiring;

   assign fetch_elig   = if_req & ~if_flush;
   assign burst_at_max = (burst_cnt_q == BURST_MAX);
   // While a ready pulse is out, the requester is still holding its old
   // request; no grant is made in that cycle so it is not served twice.
   assign retiring     = if_ready_q | dm_ready_q;

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ready_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_ready_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (!retiring) begin
               if (dm_req && !(burst_at_max && fetch_elig)) begin
                  state_d     = ST_DATA_WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = dm_we;
                  mem_size_d  = norm_size(dm_size);
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  if (if_req && !burst_at_max) begin
                     burst_cnt_d = burst_cnt_q + 1'b1;
                  end
               end else if (fetch_elig) begin
                  state_d     = ST_FETCH_WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_size_d  = FETCH_SIZE;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  burst_cnt_d = '0;
               end
            end
         end
         ST_DATA_WAIT: begin
            if (mem_ack) begin
               state_d    = ST_IDLE;
               mem_req_d  = 1'b0;
               dm_ready_d = 1'b1;
               dm_rdata_d = mem_rdata;
            end
         end
         ST_FETCH_WAIT: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (!if_flush) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else if (if_flush) begin
               state_d = ST_FETCH_DROP;
            end
         end
         ST_FETCH_DROP: begin
            // Access already issued: finish it on the bus, throw the data away.
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      // With no fetch waiting there is nothing to protect from starvation.
      if (!if_req) begin
         burst_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_ready_q  <= 1'b0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         if_rdata_q  <= if_rdata_d;
         dm_ready_q  <= dm_ready_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ready  = if_ready_q;
   assign if_rdata  = if_rdata_q;
   assign dm_ready  = dm_ready_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule : mem_port_arbiter
`default_nettype wire
